// File: rtl/puf_challenge_sequencer_pkg.sv
// Shared constants and types for the PUF challenge sequencer.
package puf_challenge_sequencer_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_FIRE   = 3'd3,
    ST_EVAL   = 3'd4,
    ST_OUTPUT = 3'd5
  } state_e;

endpackage

// File: rtl/puf_challenge_sequencer_lfsr_step.sv
// One Fibonacci LFSR step: shift left, feedback is the parity of the tapped bits.
module puf_lfsr_step #(
  parameter int unsigned     N_CB = 64,
  parameter logic [N_CB-1:0] TAPS = 64'hD800_0000_0000_0000
) (
  input  logic [N_CB-1:0] cur,
  output logic [N_CB-1:0] nxt_c
);

  // Next challenge from the current one
  always_comb begin
    nxt_c = {cur[N_CB-2:0], ^(cur & TAPS)};
  end

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Drives a sequence of LFSR challenges into the PUF array, strobes the
// arbiters and hands each captured response out over a valid/ready port.
module puf_challenge_sequencer
  import puf_challenge_sequencer_pkg::*;
#(
  parameter int unsigned     N_CB          = 64,
  parameter int unsigned     N_PUF         = 16,
  parameter int unsigned     SETTLE_CYCLES = 8,
  parameter int unsigned     EVAL_CYCLES   = 4,
  parameter logic [N_CB-1:0] TAPS          = 64'hD800_0000_0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [N_CB-1:0]    seed_i,
  input  logic [CNT_W-1:0]   n_chal_i,
  output logic [N_CB-1:0]    challenge_o,
  output logic               puf_trig_o,
  input  logic [N_PUF-1:0]   puf_resp_i,
  output logic [N_PUF-1:0]   resp_o,
  output logic               resp_valid_o,
  input  logic               resp_ready_i,
  output logic               busy_o,
  output logic               done_o
);

  state_e           state;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] phase_cnt;
  logic [N_CB-1:0]  chal_next_c;

  puf_lfsr_step #(
    .N_CB (N_CB),
    .TAPS (TAPS)
  ) u_lfsr_step (
    .cur   (challenge_o),
    .nxt_c (chal_next_c)
  );

  // Sequencer FSM with registered outputs; abort overrides every transition.
  // The LOAD cycle plus SETTLE (SETTLE_CYCLES+1 cycles) put the first
  // strobe SETTLE_CYCLES+2 edges after the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      challenge_o  <= '0;
      resp_o       <= '0;
      remaining    <= '0;
      phase_cnt    <= '0;
      puf_trig_o   <= 1'b0;
      resp_valid_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (abort_i) begin
        state        <= ST_IDLE;
        puf_trig_o   <= 1'b0;
        resp_valid_o <= 1'b0;
        busy_o       <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_i) begin
              if (n_chal_i == '0) begin
                done_o <= 1'b1;
              end else begin
                challenge_o <= (seed_i == '0) ? N_CB'(1) : seed_i;
                remaining   <= n_chal_i;
                state       <= ST_LOAD;
                busy_o      <= 1'b1;
              end
            end
          end
          ST_LOAD: begin
            phase_cnt <= '0;
            state     <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (phase_cnt == CNT_W'(SETTLE_CYCLES)) begin
              puf_trig_o <= 1'b1;
              state      <= ST_FIRE;
            end else begin
              phase_cnt <= phase_cnt + CNT_W'(1);
            end
          end
          ST_FIRE: begin
            puf_trig_o <= 1'b0;
            phase_cnt  <= '0;
            state      <= ST_EVAL;
          end
          ST_EVAL: begin
            if (phase_cnt == CNT_W'(EVAL_CYCLES - 1)) begin
              resp_o       <= puf_resp_i;
              resp_valid_o <= 1'b1;
              state        <= ST_OUTPUT;
            end else begin
              phase_cnt <= phase_cnt + CNT_W'(1);
            end
          end
          ST_OUTPUT: begin
            if (resp_valid_o && resp_ready_i) begin
              resp_valid_o <= 1'b0;
              remaining    <= remaining - CNT_W'(1);
              if (remaining == CNT_W'(1)) begin
                done_o <= 1'b1;
                busy_o <= 1'b0;
                state  <= ST_IDLE;
              end else begin
                challenge_o <= chal_next_c;
                phase_cnt   <= '0;
                state       <= ST_SETTLE;
              end
            end
          end
          default: begin
            puf_trig_o   <= 1'b0;
            resp_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            state        <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Self-checking bench for puf_challenge_sequencer (SETTLE=4, EVAL=2).
module tb_puf_challenge_sequencer;

  localparam int unsigned N_CB  = 64;
  localparam int unsigned N_PUF = 16;
  localparam logic [63:0] TAPS_TB = 64'hD800_0000_0000_0002;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_i = 1'b0;
  logic              abort_i = 1'b0;
  logic [N_CB-1:0]   seed_i = '0;
  logic [15:0]       n_chal_i = '0;
  logic [N_CB-1:0]   challenge_o;
  logic              puf_trig_o;
  logic [N_PUF-1:0]  puf_resp_i = '0;
  logic [N_PUF-1:0]  resp_o;
  logic              resp_valid_o;
  logic              resp_ready_i = 1'b0;
  logic              busy_o;
  logic              done_o;

  puf_challenge_sequencer #(
    .N_CB          (N_CB),
    .N_PUF         (N_PUF),
    .SETTLE_CYCLES (4),
    .EVAL_CYCLES   (2),
    .TAPS          (TAPS_TB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .seed_i       (seed_i),
    .n_chal_i     (n_chal_i),
    .challenge_o  (challenge_o),
    .puf_trig_o   (puf_trig_o),
    .puf_resp_i   (puf_resp_i),
    .resp_o       (resp_o),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] seed;
    logic [15:0] n;
    logic [15:0] base;
    int          stall;
    bit          busy_start;
  } vec_t;

  typedef struct {
    logic [63:0] chal;
    logic [15:0] resp;
  } exp_t;

  exp_t        sbq[$];
  logic [63:0] obs[$];
  vec_t        vecs[6];
  int          n_vec  = 0;
  int          n_miss = 0;

  function automatic logic [63:0] lfsr(input logic [63:0] m);
    return {m[62:0], ^(m & TAPS_TB)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_chal"},  challenge_o, 64'h0);
    check({name, "_resp"},  64'(resp_o), 64'h0);
    check({name, "_trig"},  64'(puf_trig_o), 64'h0);
    check({name, "_valid"}, 64'(resp_valid_o), 64'h0);
    check({name, "_busy"},  64'(busy_o), 64'h0);
    check({name, "_done"},  64'(done_o), 64'h0);
  endtask

  // Scoreboard-driven run: expectations queued at start, popped on each handshake
  task automatic run_vec(input vec_t v);
    logic [63:0] m;
    int got, dones, stall;
    m = (v.seed == 64'h0) ? 64'h1 : v.seed;
    for (int k = 0; k < int'(v.n); k++) begin
      sbq.push_back('{chal: m, resp: v.base + 16'(k)});
      m = lfsr(m);
    end
    obs.delete();
    @(negedge clk);
    seed_i = v.seed; n_chal_i = v.n; puf_resp_i = v.base; resp_ready_i = 1'b0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    got = 0; dones = 0; stall = v.stall;
    for (int cyc = 0; cyc < 3000 && dones == 0; cyc++) begin
      if (v.busy_start && cyc == 2) begin
        seed_i = 64'h77; n_chal_i = 16'd5; start_i = 1'b1;
      end else begin
        start_i = 1'b0;
      end
      if (done_o) begin
        dones++;
        resp_ready_i = 1'b0;
      end else if (resp_valid_o) begin
        if (sbq.size() == 0) begin
          check("extra_resp", 64'(resp_valid_o), 64'h0);
          resp_ready_i = 1'b1;
        end else if (stall > 0) begin
          check("stall_resp", 64'(resp_o), 64'(sbq[0].resp));
          check("stall_chal", challenge_o, sbq[0].chal);
          stall--;
          resp_ready_i = 1'b0;
        end else begin
          check("resp", 64'(resp_o), 64'(sbq[0].resp));
          check("chal", challenge_o, sbq[0].chal);
          obs.push_back(challenge_o);
          void'(sbq.pop_front());
          got++;
          resp_ready_i = 1'b1;
          puf_resp_i = v.base + 16'(got);
        end
      end else begin
        resp_ready_i = 1'b0;
      end
      @(negedge clk);
    end
    start_i = 1'b0;
    resp_ready_i = 1'b0;
    check("done_seen", 64'(dones), 64'd1);
    check("resp_count", 64'(got), 64'(v.n));
    check("busy_after_done", 64'(busy_o), 64'h0);
    @(negedge clk);
    check("done_one_cycle", 64'(done_o), 64'h0);
    sbq.delete();
  endtask

  // Edge-exact run of seed 1 / one challenge; optionally reset in OUTPUT
  task automatic timing_seq(input bit do_reset);
    @(negedge clk);
    seed_i = 64'h1; n_chal_i = 16'd1; puf_resp_i = 16'hA5A5; resp_ready_i = 1'b0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("trig_edge%0d", i), 64'(puf_trig_o), 64'(i == 6));
      check($sformatf("valid_edge%0d", i), 64'(resp_valid_o), 64'(i >= 9));
      if (i == 9) check("resp_edge9", 64'(resp_o), 64'hA5A5);
    end
    if (do_reset) begin
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      @(negedge clk);
      resp_ready_i = 1'b1;
      @(posedge clk);
      #1;
      check("t_valid_drop", 64'(resp_valid_o), 64'h0);
      check("t_done_pulse", 64'(done_o), 64'h1);
      resp_ready_i = 1'b0;
      @(posedge clk);
      #1;
      check("t_done_clear", 64'(done_o), 64'h0);
      check("t_busy_clear", 64'(busy_o), 64'h0);
    end
  endtask

  // Abort during EVAL: back to IDLE, no strobe, no response, no done
  task automatic abort_seq();
    @(negedge clk);
    seed_i = 64'h1234; n_chal_i = 16'd2; puf_resp_i = 16'h5555; resp_ready_i = 1'b1; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    abort_i = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 64'(busy_o), 64'h0);
    check("abort_trig", 64'(puf_trig_o), 64'h0);
    check("abort_valid", 64'(resp_valid_o), 64'h0);
    check("abort_done", 64'(done_o), 64'h0);
    check("abort_chal", challenge_o, 64'h1234);
    @(negedge clk);
    abort_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_quiet", 64'(done_o | resp_valid_o | busy_o), 64'h0);
    end
    resp_ready_i = 1'b0;
  endtask

  initial begin
    vecs[0] = '{seed: 64'h1,                  n: 16'd1, base: 16'hA5A5, stall: 0,  busy_start: 1'b0};
    vecs[1] = '{seed: 64'h1,                  n: 16'd3, base: 16'h1000, stall: 0,  busy_start: 1'b1};
    vecs[2] = '{seed: 64'hDEAD_BEEF_0000_1234, n: 16'd2, base: 16'h3C00, stall: 10, busy_start: 1'b0};
    vecs[3] = '{seed: 64'h0,                  n: 16'd2, base: 16'h0F0F, stall: 0,  busy_start: 1'b0};
    vecs[4] = '{seed: 64'h8000_0000_0000_0000, n: 16'd2, base: 16'h0007, stall: 0,  busy_start: 1'b0};
    vecs[5] = '{seed: 64'hABC,                n: 16'd0, base: 16'h0005, stall: 0,  busy_start: 1'b0};

    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    timing_seq(1'b0);

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
      if (i == 1) begin
        check("seq_len", 64'(obs.size()), 64'd3);
        if (obs.size() == 3) begin
          check("seq0", obs[0], 64'h1);
          check("seq1", obs[1], 64'h2);
          check("seq2", obs[2], 64'h5);
        end
      end
      if (i == 3 && obs.size() > 0) check("zero_seed", obs[0], 64'h1);
      if (i == 4 && obs.size() == 2) check("msb_seed_next", obs[1], 64'h1);
    end

    abort_seq();
    timing_seq(1'b1);
    timing_seq(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
